// File: rtl/simple_bus_arbiter_if.sv
// rtl/simple_bus_arbiter_if.sv - master-side request bundle and shared target bus for simple_bus_arbiter
interface simple_bus_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int MODE_W  = 2
);
   logic [NUM_REQ-1:0]        m_req;
   logic [NUM_REQ-1:0]        m_gnt;
   logic [NUM_REQ*ADDR_W-1:0] m_addr;
   logic [NUM_REQ*DATA_W-1:0] m_data;
   logic [NUM_REQ*MODE_W-1:0] m_mode;
   logic [NUM_REQ-1:0]        m_start;
   logic [NUM_REQ-1:0]        m_rdy;
   logic                      s_req;
   logic [ADDR_W-1:0]         s_addr;
   logic [DATA_W-1:0]         s_data;
   logic [MODE_W-1:0]         s_mode;
   logic                      s_start;
   logic                      s_rdy;

   // Environment side: the requesting masters plus the memory target.
   modport master (
      output m_req, m_addr, m_data, m_mode, m_start, s_rdy,
      input  m_gnt, m_rdy, s_req, s_addr, s_data, s_mode, s_start
   );

   // Arbiter side.
   modport slave (
      input  m_req, m_addr, m_data, m_mode, m_start, s_rdy,
      output m_gnt, m_rdy, s_req, s_addr, s_data, s_mode, s_start
   );
endinterface

// File: rtl/simple_bus_arbiter.sv
// rtl/simple_bus_arbiter.sv - round-robin arbiter sharing one simple_bus target; optional watchdog via SIMPLE_BUS_ARB_TIMEOUT_EN
module simple_bus_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int MODE_W  = 2,
   parameter int TIMEOUT = 15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   simple_bus_arbiter_if.slave  bus,
   output logic                 err
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      BUSY    = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   sel_q, sel_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_found;
   logic               grant_active;
   logic               timeout;

`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] busy_cnt_q;

   // Counts completed BUSY cycles; held at zero outside BUSY so every transaction starts fresh.
   always_ff @(posedge clk) begin
      if (!rst_n)
         busy_cnt_q <= '0;
      else if (state_q != BUSY)
         busy_cnt_q <= '0;
      else
         busy_cnt_q <= busy_cnt_q + 1'b1;
   end

   // The current BUSY cycle is the TIMEOUT-th one; completion in that cycle still wins.
   assign timeout = (state_q == BUSY) && (busy_cnt_q == CNT_W'(TIMEOUT - 1));
   assign err     = timeout && !bus.s_rdy;
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

   // Round-robin pick: first requester at or after ptr, wrapping past the last master.
   always_comb begin
      pick_idx   = '0;
      pick_found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         int idx;
         idx = int'(ptr_q) + k;
         if (idx >= NUM_REQ)
            idx = idx - NUM_REQ;
         if (!pick_found && bus.m_req[idx]) begin
            pick_found = 1'b1;
            pick_idx   = IDX_W'(idx);
         end
      end
   end

   // Next-state logic; the grant register is set on entry to GRANT and cleared on the way to RELEASE.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               sel_d   = pick_idx;
               gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (bus.m_start[sel_q]) begin
               state_d = BUSY;
            end else if (!bus.m_req[sel_q]) begin
               gnt_d   = '0;
               state_d = RELEASE;
            end
         end
         BUSY: begin
            if (bus.s_rdy || timeout) begin
               gnt_d   = '0;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            ptr_d   = (sel_q == IDX_W'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;
            state_d = IDLE;
         end
         default: begin
            gnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // State, selection, pointer and grant registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= '0;
         ptr_q   <= '0;
         gnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
      end
   end

   assign grant_active = (state_q == GRANT) || (state_q == BUSY);

   // Steer the granted master onto the target and route completion back to it alone.
   always_comb begin
      bus.m_gnt   = gnt_q;
      bus.s_req   = (state_q == BUSY);
      bus.m_rdy   = ((state_q == BUSY) && bus.s_rdy) ? gnt_q : '0;
      bus.s_addr  = '0;
      bus.s_data  = '0;
      bus.s_mode  = '0;
      bus.s_start = 1'b0;
      if (grant_active) begin
         bus.s_addr  = bus.m_addr[int'(sel_q)*ADDR_W +: ADDR_W];
         bus.s_data  = bus.m_data[int'(sel_q)*DATA_W +: DATA_W];
         bus.s_mode  = bus.m_mode[int'(sel_q)*MODE_W +: MODE_W];
         bus.s_start = bus.m_start[sel_q];
      end
   end
endmodule

// File: tb/tb_simple_bus_arbiter.sv
// tb/tb_simple_bus_arbiter.sv - directed self-checking bench for simple_bus_arbiter
module tb_simple_bus_arbiter;
   logic clk;
   logic rst_n;
   logic err;
   int   n_cmp;
   int   n_bad;

   simple_bus_arbiter_if #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(8), .MODE_W(2)) bus ();

   simple_bus_arbiter #(
      .NUM_REQ(4), .ADDR_W(8), .DATA_W(8), .MODE_W(2), .TIMEOUT(15)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic apply_reset();
      rst_n       = 1'b0;
      bus.m_req   = '0;
      bus.m_start = '0;
      bus.s_rdy   = 1'b0;
      bus.m_addr  = '0;
      bus.m_data  = '0;
      bus.m_mode  = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      bus.m_req   = 4'b1111;
      bus.m_start = 4'b1111;
      bus.s_rdy   = 1'b1;
      bus.m_addr  = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
      bus.m_data  = {8'h44, 8'h33, 8'h22, 8'h11};
      bus.m_mode  = {2'b11, 2'b10, 2'b01, 2'b11};
      repeat (3) @(negedge clk);
      n_cmp++; if (bus.m_gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt: got %b want 0000", bus.m_gnt); end
      n_cmp++; if (bus.m_rdy !== 4'b0000) begin n_bad++; $display("FAIL reset_rdy: got %b want 0000", bus.m_rdy); end
      n_cmp++; if (bus.s_req !== 1'b0) begin n_bad++; $display("FAIL reset_s_req: got %b want 0", bus.s_req); end
      n_cmp++; if (bus.s_start !== 1'b0) begin n_bad++; $display("FAIL reset_s_start: got %b want 0", bus.s_start); end
      n_cmp++; if (bus.s_addr !== 8'h00) begin n_bad++; $display("FAIL reset_s_addr: got %h want 00", bus.s_addr); end
      n_cmp++; if (bus.s_data !== 8'h00) begin n_bad++; $display("FAIL reset_s_data: got %h want 00", bus.s_data); end
      n_cmp++; if (bus.s_mode !== 2'b00) begin n_bad++; $display("FAIL reset_s_mode: got %b want 00", bus.s_mode); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
      rst_n       = 1'b1;
      bus.m_start = 4'b0000;
      bus.s_rdy   = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.m_gnt !== 4'b0001) begin n_bad++; $display("FAIL reset_first_gnt: got %b want 0001", bus.m_gnt); end
      n_cmp++; if (bus.s_addr !== 8'hA1) begin n_bad++; $display("FAIL reset_first_addr: got %h want a1", bus.s_addr); end
   endtask

   task automatic test_single_master2();
      apply_reset();
      bus.m_addr = {8'h44, 8'h3C, 8'h22, 8'h11};
      bus.m_data = {8'hD0, 8'h5A, 8'hB0, 8'hA0};
      bus.m_mode = {2'b11, 2'b10, 2'b01, 2'b00};
      bus.m_req  = 4'b0100;
      #1;
      n_cmp++; if (bus.m_gnt !== 4'b0000) begin n_bad++; $display("FAIL single_idle_gnt: got %b want 0000", bus.m_gnt); end
      @(negedge clk);
      n_cmp++; if (bus.m_gnt !== 4'b0100) begin n_bad++; $display("FAIL single_gnt: got %b want 0100", bus.m_gnt); end
      n_cmp++; if (bus.s_req !== 1'b0) begin n_bad++; $display("FAIL single_grant_s_req: got %b want 0", bus.s_req); end
      bus.m_start = 4'b0100;
      #1;
      n_cmp++; if (bus.s_start !== 1'b1) begin n_bad++; $display("FAIL single_s_start: got %b want 1", bus.s_start); end
      n_cmp++; if (bus.s_addr !== 8'h3C) begin n_bad++; $display("FAIL single_s_addr: got %h want 3c", bus.s_addr); end
      n_cmp++; if (bus.s_data !== 8'h5A) begin n_bad++; $display("FAIL single_s_data: got %h want 5a", bus.s_data); end
      n_cmp++; if (bus.s_mode !== 2'b10) begin n_bad++; $display("FAIL single_s_mode: got %b want 10", bus.s_mode); end
      @(negedge clk);
      bus.m_start = 4'b0000;
      #1;
      n_cmp++; if (bus.s_req !== 1'b1) begin n_bad++; $display("FAIL single_busy_s_req: got %b want 1", bus.s_req); end
      n_cmp++; if (bus.m_rdy !== 4'b0000) begin n_bad++; $display("FAIL single_busy1_rdy: got %b want 0000", bus.m_rdy); end
      @(negedge clk);
      bus.s_rdy = 1'b1;
      #1;
      n_cmp++; if (bus.m_rdy !== 4'b0100) begin n_bad++; $display("FAIL single_rdy: got %b want 0100", bus.m_rdy); end
      @(negedge clk);
      n_cmp++; if (bus.m_rdy !== 4'b0000) begin n_bad++; $display("FAIL single_rdy_once: got %b want 0000", bus.m_rdy); end
      n_cmp++; if (bus.m_gnt !== 4'b0000) begin n_bad++; $display("FAIL single_release_gnt: got %b want 0000", bus.m_gnt); end
      bus.s_rdy = 1'b0;
      bus.m_req = 4'b1001;
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if (bus.m_gnt !== 4'b1000) begin n_bad++; $display("FAIL single_ptr3: got %b want 1000", bus.m_gnt); end
      bus.m_req = 4'b0000;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_gnt;
      logic [3:0] exp_rdy;
      int         order [5] = '{0, 1, 2, 3, 0};
      apply_reset();
      bus.m_req = 4'b1111;
      bus.s_rdy = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         bus.m_start = bus.m_gnt;
         #1;
         exp_gnt = (((i - 1) % 4) < 2) ? (4'b0001 << order[(i - 1) / 4]) : 4'b0000;
         exp_rdy = (((i - 1) % 4) == 1) ? exp_gnt : 4'b0000;
         n_cmp++; if (bus.m_gnt !== exp_gnt) begin n_bad++; $display("FAIL rr_gnt cycle %0d: got %b want %b", i, bus.m_gnt, exp_gnt); end
         n_cmp++; if (bus.m_rdy !== exp_rdy) begin n_bad++; $display("FAIL rr_rdy cycle %0d: got %b want %b", i, bus.m_rdy, exp_rdy); end
         n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rr_err cycle %0d: got %b want 0", i, err); end
      end
   endtask

   task automatic test_wrap_skip();
      apply_reset();
      bus.m_req   = 4'b0100;
      bus.m_start = 4'b0100;
      bus.s_rdy   = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if (bus.m_rdy !== 4'b0100) begin n_bad++; $display("FAIL wrap_pre_rdy: got %b want 0100", bus.m_rdy); end
      bus.m_req   = 4'b1010;
      bus.m_start = 4'b0000;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if (bus.m_gnt !== 4'b1000) begin n_bad++; $display("FAIL wrap_gnt3: got %b want 1000", bus.m_gnt); end
      bus.m_start = 4'b0010;
      #1;
      n_cmp++; if (bus.s_start !== 1'b0) begin n_bad++; $display("FAIL wrap_foreign_start: got %b want 0", bus.s_start); end
      @(negedge clk);
      n_cmp++; if (bus.m_gnt !== 4'b1000) begin n_bad++; $display("FAIL wrap_hold_gnt: got %b want 1000", bus.m_gnt); end
      n_cmp++; if (bus.s_req !== 1'b0) begin n_bad++; $display("FAIL wrap_hold_s_req: got %b want 0", bus.s_req); end
      bus.m_start = 4'b1000;
      #1;
      n_cmp++; if (bus.s_start !== 1'b1) begin n_bad++; $display("FAIL wrap_own_start: got %b want 1", bus.s_start); end
      @(negedge clk);
      bus.m_start = 4'b0000;
      #1;
      n_cmp++; if (bus.m_rdy !== 4'b1000) begin n_bad++; $display("FAIL wrap_rdy3: got %b want 1000", bus.m_rdy); end
      @(negedge clk);
      n_cmp++; if (bus.m_gnt !== 4'b0000) begin n_bad++; $display("FAIL wrap_release: got %b want 0000", bus.m_gnt); end
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if (bus.m_gnt !== 4'b0010) begin n_bad++; $display("FAIL wrap_gnt1: got %b want 0010", bus.m_gnt); end
      bus.m_start = 4'b0010;
      @(negedge clk);
      bus.m_req   = 4'b0000;
      bus.m_start = 4'b0000;
      repeat (3) @(negedge clk);
      n_cmp++; if (bus.m_gnt !== 4'b0000) begin n_bad++; $display("FAIL wrap_quiet: got %b want 0000", bus.m_gnt); end
   endtask

   task automatic test_abort();
      apply_reset();
      bus.m_req = 4'b0010;
      @(negedge clk);
      n_cmp++; if (bus.m_gnt !== 4'b0010) begin n_bad++; $display("FAIL abort_gnt: got %b want 0010", bus.m_gnt); end
      bus.m_req = 4'b0000;
      @(negedge clk);
      n_cmp++; if (bus.m_gnt !== 4'b0000) begin n_bad++; $display("FAIL abort_release_gnt: got %b want 0000", bus.m_gnt); end
      n_cmp++; if (bus.s_req !== 1'b0) begin n_bad++; $display("FAIL abort_s_req: got %b want 0", bus.s_req); end
      bus.m_req = 4'b0111;
      @(negedge clk);
      n_cmp++; if (bus.s_req !== 1'b0) begin n_bad++; $display("FAIL abort_idle_s_req: got %b want 0", bus.s_req); end
      @(negedge clk);
      n_cmp++; if (bus.m_gnt !== 4'b0100) begin n_bad++; $display("FAIL abort_ptr2: got %b want 0100", bus.m_gnt); end
      bus.m_req = 4'b0000;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      apply_reset();
      bus.m_req  = 4'b0001;
      bus.m_addr = {8'h00, 8'h00, 8'h00, 8'h77};
      @(negedge clk);
      bus.m_start = 4'b0001;
      @(negedge clk);
      bus.m_start = 4'b0000;
      #1;
      n_cmp++; if (bus.s_req !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %b want 1", bus.s_req); end
      rst_n = 1'b0;
      @(negedge clk);
      bus.s_rdy = 1'b1;
      #1;
      n_cmp++; if (bus.m_gnt !== 4'b0000) begin n_bad++; $display("FAIL mid_gnt: got %b want 0000", bus.m_gnt); end
      n_cmp++; if (bus.m_rdy !== 4'b0000) begin n_bad++; $display("FAIL mid_rdy: got %b want 0000", bus.m_rdy); end
      n_cmp++; if (bus.s_req !== 1'b0) begin n_bad++; $display("FAIL mid_s_req: got %b want 0", bus.s_req); end
      n_cmp++; if (bus.s_addr !== 8'h00) begin n_bad++; $display("FAIL mid_s_addr: got %h want 00", bus.s_addr); end
      bus.s_rdy = 1'b0;
      bus.m_req = 4'b0000;
      rst_n     = 1'b1;
      @(negedge clk);
   endtask

`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
   task automatic test_timeout();
      apply_reset();
      bus.m_req = 4'b0011;
      @(negedge clk);
      bus.m_start = 4'b0001;
      @(negedge clk);
      bus.m_start = 4'b0000;
      for (int b = 1; b <= 15; b++) begin
         if (b > 1) @(negedge clk);
         #1;
         n_cmp++; if (err !== (b == 15)) begin n_bad++; $display("FAIL to_err busy cycle %0d: got %b want %b", b, err, (b == 15)); end
      end
      @(negedge clk);
      n_cmp++; if (bus.m_gnt !== 4'b0000) begin n_bad++; $display("FAIL to_release: got %b want 0000", bus.m_gnt); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL to_err_once: got %b want 0", err); end
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if (bus.m_gnt !== 4'b0010) begin n_bad++; $display("FAIL to_next: got %b want 0010", bus.m_gnt); end
      bus.m_start = 4'b0010;
      @(negedge clk);
      bus.m_start = 4'b0000;
      bus.m_req   = 4'b0000;
      for (int b = 1; b <= 15; b++) begin
         if (b > 1) @(negedge clk);
         bus.s_rdy = (b == 15);
         #1;
         n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL to_race_err cycle %0d: got %b want 0", b, err); end
      end
      n_cmp++; if (bus.m_rdy !== 4'b0010) begin n_bad++; $display("FAIL to_race_rdy: got %b want 0010", bus.m_rdy); end
      @(negedge clk);
      bus.s_rdy = 1'b0;
   endtask
`endif

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      bus.m_req   = '0;
      bus.m_start = '0;
      bus.s_rdy   = 1'b0;
      bus.m_addr  = '0;
      bus.m_data  = '0;
      bus.m_mode  = '0;
      @(negedge clk);
      test_reset();
      test_single_master2();
      test_round_robin();
      test_wrap_skip();
      test_abort();
      test_reset_mid();
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
